// File: rtl/countdown_timer.sv
// MM:SS count-down timer: loads a preset, decrements it once per TICK_DIV running
// clocks and pulses done for one cycle when the count reaches 00:00.
module countdown_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [7:0] i_load_min,
    input  logic [5:0] i_load_sec,
    output logic [7:0] o_minutes,
    output logic [5:0] o_seconds,
    output logic [1:0] o_status,
    output logic       o_done
);

    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_min, w_min_nxt;
    logic [5:0]      r_sec, w_sec_nxt;
    logic [PW-1:0]   r_presc, w_presc_nxt;
    logic            r_done, w_done_nxt;

    logic [5:0]      w_load_sec_sat;
    logic            w_tick;
    logic            w_nonzero;
    logic [7:0]      w_dec_min;
    logic [5:0]      w_dec_sec;
    logic            w_dec_zero;

    assign w_load_sec_sat = (i_load_sec > 6'd59) ? 6'd59 : i_load_sec;
    assign w_tick         = (r_presc == PS_LAST);
    assign w_nonzero      = (r_min != 8'd0) || (r_sec != 6'd0);

    // One-second decrement with borrow from minutes; holds at 00:00.
    always_comb begin
        w_dec_min = r_min;
        w_dec_sec = r_sec;
        if (r_sec != 6'd0) begin
            w_dec_sec = r_sec - 6'd1;
        end else if (r_min != 8'd0) begin
            w_dec_min = r_min - 8'd1;
            w_dec_sec = 6'd59;
        end
    end

    assign w_dec_zero = (w_dec_min == 8'd0) && (w_dec_sec == 6'd0);

    // Priority: reset > load > stop > start > tick; a raised stop masks start.
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;

        if (i_reset) begin
            w_state_nxt = ST_IDLE;
            w_min_nxt   = 8'd0;
            w_sec_nxt   = 6'd0;
            w_presc_nxt = '0;
        end else if (i_load && (r_state != ST_RUNNING)) begin
            w_state_nxt = ST_IDLE;
            w_min_nxt   = i_load_min;
            w_sec_nxt   = w_load_sec_sat;
            w_presc_nxt = '0;
        end else if (i_stop) begin
            if (r_state == ST_RUNNING) begin
                w_state_nxt = ST_PAUSED;
            end
        end else if (i_start && (((r_state == ST_IDLE) && w_nonzero) ||
                                 (r_state == ST_PAUSED))) begin
            w_state_nxt = ST_RUNNING;
        end else if (r_state == ST_RUNNING) begin
            if (w_tick) begin
                w_presc_nxt = '0;
                w_min_nxt   = w_dec_min;
                w_sec_nxt   = w_dec_sec;
                if (w_dec_zero) begin
                    w_state_nxt = ST_EXPIRED;
                    w_done_nxt  = 1'b1;
                end
            end else begin
                w_presc_nxt = r_presc + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_min   <= 8'd0;
            r_sec   <= 6'd0;
            r_presc <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
            r_presc <= w_presc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_minutes = r_min;
    assign o_seconds = r_sec;
    assign o_status  = r_state;
    assign o_done    = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed-vector bench for countdown_timer: a TICK_DIV=1 instance driven from a
// table plus hand sequences, and a TICK_DIV=4 instance for prescaler hold/resume.
module tb_countdown_timer;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_PAU  = 2'b10;
    localparam logic [1:0] S_EXP  = 2'b11;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       start = 1'b0, stop = 1'b0, syncReset = 1'b0, load = 1'b0;
    logic [7:0] loadMin = 8'd0;
    logic [5:0] loadSec = 6'd0;

    logic [7:0] min1, min4;
    logic [5:0] sec1, sec4;
    logic [1:0] stat1, stat4;
    logic       done1, done4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    countdown_timer #(.TICK_DIV(1)) dut1 (
        .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_stop(stop),
        .i_reset(syncReset), .i_load(load), .i_load_min(loadMin), .i_load_sec(loadSec),
        .o_minutes(min1), .o_seconds(sec1), .o_status(stat1), .o_done(done1)
    );

    countdown_timer #(.TICK_DIV(4)) dut4 (
        .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_stop(stop),
        .i_reset(syncReset), .i_load(load), .i_load_min(loadMin), .i_load_sec(loadSec),
        .o_minutes(min4), .o_seconds(sec4), .o_status(stat4), .o_done(done4)
    );

    typedef struct {
        logic       vStart;
        logic       vStop;
        logic       vReset;
        logic       vLoad;
        logic [7:0] vMin;
        logic [5:0] vSec;
        logic [7:0] eMin;
        logic [5:0] eSec;
        logic [1:0] eStat;
        logic       eDone;
    } vec_t;

    vec_t vecs[$];

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic st, input logic sp, input logic rs,
                                 input logic ld, input logic [7:0] lm, input logic [5:0] ls);
        @(negedge clk);
        start     = st;
        stop      = sp;
        syncReset = rs;
        load      = ld;
        loadMin   = lm;
        loadSec   = ls;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name,
                               input logic [7:0] aMin, input logic [5:0] aSec,
                               input logic [1:0] aStat, input logic aDone,
                               input logic [7:0] eMin, input logic [5:0] eSec,
                               input logic [1:0] eStat, input logic eDone);
        total++;
        if (aMin !== eMin || aSec !== eSec || aStat !== eStat || aDone !== eDone) begin
            bad++;
            $display("[TB] FAIL %s: got %0d:%0d status=%b done=%b, expected %0d:%0d status=%b done=%b",
                     name, aMin, aSec, aStat, aDone, eMin, eSec, eStat, eDone);
        end
    endtask

    task automatic check1(input string name, input logic [7:0] eMin, input logic [5:0] eSec,
                          input logic [1:0] eStat, input logic eDone);
        checkOutput(name, min1, sec1, stat1, done1, eMin, eSec, eStat, eDone);
    endtask

    task automatic check4(input string name, input logic [7:0] eMin, input logic [5:0] eSec,
                          input logic [1:0] eStat, input logic eDone);
        checkOutput(name, min4, sec4, stat4, done4, eMin, eSec, eStat, eDone);
    endtask

    initial begin
        //                start stop  rst   load  lmin   lsec     emin   esec    estat   edone
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  6'd3,    8'd0,  6'd3,  S_IDLE, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd3,  S_RUN,  1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd2,  S_RUN,  1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd1,  S_RUN,  1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd0,  S_EXP,  1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd0,  S_EXP,  1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd0,  S_EXP,  1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd0,  S_EXP,  1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  6'd5,    8'd0,  6'd5,  S_IDLE, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd5,  S_RUN,  1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd5,  S_PAU,  1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd5,  S_PAU,  1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd5,  S_RUN,  1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd2,  6'd10,   8'd0,  6'd4,  S_RUN,  1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd4,  S_PAU,  1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd1,  6'd63,   8'd1,  6'd59, S_IDLE, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'd7,  6'd7,    8'd0,  6'd0,  S_IDLE, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd0,  S_IDLE, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd1,  6'd0,    8'd1,  6'd0,  S_IDLE, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  6'd0,    8'd1,  6'd0,  S_RUN,  1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  6'd0,    8'd0,  6'd59, S_RUN,  1'b0});

        #12;
        check1("async_reset_dut1", 8'd0, 6'd0, S_IDLE, 1'b0);
        check4("async_reset_dut4", 8'd0, 6'd0, S_IDLE, 1'b0);
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].vStart, vecs[i].vStop, vecs[i].vReset, vecs[i].vLoad,
                          vecs[i].vMin, vecs[i].vSec);
            check1($sformatf("vec%0d", i), vecs[i].eMin, vecs[i].eSec, vecs[i].eStat, vecs[i].eDone);
        end

        // 00:59 counts down to 00:01 over 58 edges, then expires on the next.
        for (int k = 1; k <= 58; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
            check1($sformatf("minute_run_%0d", k), 8'd0, 6'(59 - k), S_RUN, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check1("minute_expire", 8'd0, 6'd0, S_EXP, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check1("minute_done_drop", 8'd0, 6'd0, S_EXP, 1'b0);

        // Synchronous reset on the final-tick edge suppresses done.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 6'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check1("pre_final_tick", 8'd0, 6'd1, S_RUN, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 6'd0);
        check1("reset_on_final", 8'd0, 6'd0, S_IDLE, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check1("reset_on_final_after", 8'd0, 6'd0, S_IDLE, 1'b0);

        // Asynchronous rst_n pulse between edges while running.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 6'd9);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check1("pre_abort", 8'd0, 6'd8, S_RUN, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        check1("rstn_abort", 8'd0, 6'd0, S_IDLE, 1'b0);
        @(negedge clk);
        rstN = 1'b1;

        // TICK_DIV=4: pause with prescaler at 2, resume, and decrement two edges later.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 6'd2);
        check4("div4_load", 8'd0, 6'd2, S_IDLE, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check4("div4_enter", 8'd0, 6'd2, S_RUN, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check4("div4_run2", 8'd0, 6'd2, S_RUN, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 6'd0);
        check4("div4_pause", 8'd0, 6'd2, S_PAU, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check4("div4_hold", 8'd0, 6'd2, S_PAU, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check4("div4_resume", 8'd0, 6'd2, S_RUN, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check4("div4_resume_1", 8'd0, 6'd2, S_RUN, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check4("div4_first_dec", 8'd0, 6'd1, S_RUN, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
            check4($sformatf("div4_wait_%0d", k), 8'd0, 6'd1, S_RUN, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check4("div4_expire", 8'd0, 6'd0, S_EXP, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        check4("div4_done_drop", 8'd0, 6'd0, S_EXP, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
